wb_dma_copy_engine: RTL and testbench



---
 rtl/wb_dma_copy_engine_pkg.sv | 19 +
 rtl/wb_dma_copy_engine_addr_gen.sv | 42 ++++
 rtl/wb_dma_copy_engine.sv | 181 ++++++++++++++++++
 tb/tb_wb_dma_copy_engine.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_dma_copy_engine_pkg.sv
// Shared types and constants for the Wishbone block-copy engine.
package wb_dma_copy_engine_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_REQ  = 3'd1,
    RD_WAIT = 3'd2,
    WR_REQ  = 3'd3,
    WR_WAIT = 3'd4,
    DONE    = 3'd5
  } state_e;

  // Byte-address step between consecutive 32-bit words
  localparam int unsigned WORD_INC = 4;

  // All four byte lanes enabled
  localparam logic [3:0] SEL_FULL = 4'hF;

endpackage

// File: rtl/wb_dma_copy_engine_addr_gen.sv
// Source/destination address and remaining-word bookkeeping for the copy engine.
module wb_dma_copy_engine_addr_gen
  import wb_dma_copy_engine_pkg::*;
#(
  parameter int unsigned aw = 32,
  parameter int unsigned CW = 16
) (
  input  logic          wb_clk,
  input  logic          wb_rst_n,
  input  logic          load,
  input  logic          step,
  input  logic [aw-1:0] src_in,
  input  logic [aw-1:0] dst_in,
  input  logic [CW-1:0] count_in,
  output logic [aw-1:0] src,
  output logic [aw-1:0] dst,
  output logic          last_c
);

  logic [CW-1:0] remaining;

  // Latch operands on a new command, advance by one word after each good write
  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      src       <= '0;
      dst       <= '0;
      remaining <= '0;
    end else if (load) begin
      src       <= src_in;
      dst       <= dst_in;
      remaining <= count_in;
    end else if (step) begin
      src       <= src + aw'(WORD_INC);
      dst       <= dst + aw'(WORD_INC);
      remaining <= remaining - CW'(1);
    end
  end

  // Current word is the final one of the command
  assign last_c = (remaining == CW'(1));

endmodule

// File: rtl/wb_dma_copy_engine.sv
// Block-copy sequencer: turns one (src, dst, count) command into alternating
// single-word read/write requests on the Wishbone master start/active handshake.
module wb_dma_copy_engine
  import wb_dma_copy_engine_pkg::*;
#(
  parameter int unsigned dw = 32,
  parameter int unsigned aw = 32,
  parameter int unsigned CW = 16
) (
  input  logic          wb_clk,
  input  logic          wb_rst_n,
  input  logic          go,
  input  logic [aw-1:0] src_addr,
  input  logic [aw-1:0] dst_addr,
  input  logic [CW-1:0] word_count,
  output logic          mst_start,
  output logic [aw-1:0] mst_address,
  output logic [3:0]    mst_selection,
  output logic          mst_write,
  output logic [dw-1:0] mst_data_wr,
  input  logic [dw-1:0] mst_data_rd,
  input  logic          mst_active,
  input  logic          mst_err,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [CW-1:0] words_done
);

  state_e        state_q, state_d;
  logic          abort_q, abort_d;
  logic          start_d, write_d, busy_d, done_d, err_d;
  logic [aw-1:0] addr_d;
  logic [3:0]    sel_d;
  logic [dw-1:0] data_d;
  logic [CW-1:0] words_d;
  logic          load, step;
  logic [aw-1:0] src_q, dst_q;
  logic          last_c;
  logic          fail_c;

  wb_dma_copy_engine_addr_gen #(
    .aw (aw),
    .CW (CW)
  ) u_addr_gen (
    .wb_clk   (wb_clk),
    .wb_rst_n (wb_rst_n),
    .load     (load),
    .step     (step),
    .src_in   (src_addr),
    .dst_in   (dst_addr),
    .count_in (word_count),
    .src      (src_q),
    .dst      (dst_q),
    .last_c   (last_c)
  );

  // Transaction is lost if an error arrived now or earlier in this wait
  assign fail_c = abort_q | mst_err;

  // State and registered-output flops
  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      state_q       <= IDLE;
      abort_q       <= 1'b0;
      mst_start     <= 1'b0;
      mst_address   <= '0;
      mst_selection <= '0;
      mst_write     <= 1'b0;
      mst_data_wr   <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      err           <= 1'b0;
      words_done    <= '0;
    end else begin
      state_q       <= state_d;
      abort_q       <= abort_d;
      mst_start     <= start_d;
      mst_address   <= addr_d;
      mst_selection <= sel_d;
      mst_write     <= write_d;
      mst_data_wr   <= data_d;
      busy          <= busy_d;
      done          <= done_d;
      err           <= err_d;
      words_done    <= words_d;
    end
  end

  // Next state and next values of the registered outputs
  always_comb begin
    state_d = state_q;
    abort_d = abort_q;
    start_d = 1'b0;
    addr_d  = mst_address;
    sel_d   = mst_selection;
    write_d = mst_write;
    data_d  = mst_data_wr;
    err_d   = err;
    words_d = words_done;
    load    = 1'b0;
    step    = 1'b0;

    case (state_q)
      IDLE: begin
        if (go) begin
          err_d   = 1'b0;
          words_d = '0;
          abort_d = 1'b0;
          if (word_count == '0) begin
            state_d = DONE;
          end else begin
            load    = 1'b1;
            state_d = RD_REQ;
            start_d = 1'b1;
            addr_d  = src_addr;
            sel_d   = SEL_FULL;
            write_d = 1'b0;
            data_d  = '0;
          end
        end
      end

      RD_REQ: state_d = RD_WAIT;

      RD_WAIT: begin
        if (mst_err) begin
          err_d   = 1'b1;
          abort_d = 1'b1;
        end
        if (!mst_active) begin
          if (fail_c) begin
            state_d = DONE;
          end else begin
            state_d = WR_REQ;
            start_d = 1'b1;
            addr_d  = dst_q;
            sel_d   = SEL_FULL;
            write_d = 1'b1;
            data_d  = mst_data_rd;
          end
        end
      end

      WR_REQ: state_d = WR_WAIT;

      WR_WAIT: begin
        if (mst_err) begin
          err_d   = 1'b1;
          abort_d = 1'b1;
        end
        if (!mst_active) begin
          if (fail_c) begin
            state_d = DONE;
          end else begin
            step    = 1'b1;
            words_d = words_done + CW'(1);
            if (last_c) begin
              state_d = DONE;
            end else begin
              state_d = RD_REQ;
              start_d = 1'b1;
              addr_d  = src_q + aw'(WORD_INC);
              sel_d   = SEL_FULL;
              write_d = 1'b0;
              data_d  = '0;
            end
          end
        end
      end

      DONE: state_d = IDLE;

      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

endmodule

// File: tb/tb_wb_dma_copy_engine.sv
// Self-checking bench for wb_dma_copy_engine with a behavioural master/slave model.
module tb_wb_dma_copy_engine;

  logic        wb_clk = 1'b0;
  logic        wb_rst_n;
  logic        go;
  logic [31:0] src_addr, dst_addr;
  logic [15:0] word_count;
  logic        mst_start, mst_write;
  logic [31:0] mst_address, mst_data_wr;
  logic [3:0]  mst_selection;
  logic        busy, done, err;
  logic [15:0] words_done;

  // Master + slave model state
  logic        m_active, m_err, m_we, m_hit;
  logic [31:0] m_addr, m_wdata, m_rdata;
  int          m_cnt;
  int          total_starts = 0;
  int          wr_cnt = 0;
  int          rd_cnt = 0;
  int          proto_bad = 0;
  int          wait_states = 0;
  int          err_target = 0;
  logic [31:0] wr_log_a [64];
  logic [31:0] wr_log_d [64];
  logic [31:0] rd_log   [64];

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0] src;
    logic [31:0] dst;
    logic [15:0] count;
    int          err_start;   // 1-based start number within the command that errors, 0 = none
    int          waits;
    int          exp_words;
    bit          exp_err;
    int          exp_starts;
  } cmd_t;

  cmd_t tbl[$];

  always #5 wb_clk = ~wb_clk;

  wb_dma_copy_engine dut (
    .wb_clk        (wb_clk),
    .wb_rst_n      (wb_rst_n),
    .go            (go),
    .src_addr      (src_addr),
    .dst_addr      (dst_addr),
    .word_count    (word_count),
    .mst_start     (mst_start),
    .mst_address   (mst_address),
    .mst_selection (mst_selection),
    .mst_write     (mst_write),
    .mst_data_wr   (mst_data_wr),
    .mst_data_rd   (m_rdata),
    .mst_active    (m_active),
    .mst_err       (m_err),
    .busy          (busy),
    .done          (done),
    .err           (err),
    .words_done    (words_done)
  );

  // Memory contents seen by reads: a fixed function of the address
  function automatic logic [31:0] rd_val(input logic [31:0] a);
    return {a[15:0] ^ 16'hC3A5, ~a[31:16]};
  endfunction

  // Master registers start, stays active for wait_states+1 cycles, then returns data/err
  always @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      m_active <= 1'b0;
      m_err    <= 1'b0;
      m_cnt    <= 0;
      m_hit    <= 1'b0;
    end else begin
      m_err <= 1'b0;
      if (mst_start) begin
        if (m_active || mst_selection != 4'hF || (!mst_write && mst_data_wr != 32'h0))
          proto_bad <= proto_bad + 1;
        m_active     <= 1'b1;
        m_addr       <= mst_address;
        m_we         <= mst_write;
        m_wdata      <= mst_data_wr;
        m_cnt        <= wait_states;
        m_hit        <= (total_starts + 1 == err_target);
        total_starts <= total_starts + 1;
        if (!mst_write) begin
          rd_log[rd_cnt[5:0]] <= mst_address;
          rd_cnt <= rd_cnt + 1;
        end
      end else if (m_active) begin
        if (m_cnt == 0) begin
          m_active <= 1'b0;
          if (m_hit) begin
            m_err   <= 1'b1;
            m_rdata <= 32'hBAD0_BAD0;
          end else if (m_we) begin
            wr_log_a[wr_cnt[5:0]] <= m_addr;
            wr_log_d[wr_cnt[5:0]] <= m_wdata;
            wr_cnt <= wr_cnt + 1;
          end else begin
            m_rdata <= rd_val(m_addr);
          end
        end else begin
          m_cnt <= m_cnt - 1;
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference outcome of a command from the copy/abort rules alone
  function automatic cmd_t expect_of(input cmd_t c);
    cmd_t r = c;
    if (c.err_start == 0) begin
      r.exp_words  = int'(c.count);
      r.exp_err    = 1'b0;
      r.exp_starts = 2 * int'(c.count);
    end else begin
      r.exp_words  = (c.err_start - 1) / 2;
      r.exp_err    = 1'b1;
      r.exp_starts = c.err_start;
    end
    return r;
  endfunction

  function automatic cmd_t mk(input logic [31:0] s, input logic [31:0] d, input logic [15:0] n,
                              input int es, input int w, input int ew, input bit ee, input int est);
    cmd_t c;
    c.src = s; c.dst = d; c.count = n; c.err_start = es; c.waits = w;
    c.exp_words = ew; c.exp_err = ee; c.exp_starts = est;
    return c;
  endfunction

  task automatic run_cmd(input cmd_t c, input bit inject);
    int base_st, base_wr, base_rd, cyc, n_rd;
    bit seen;
    wait_states = c.waits;
    base_st = total_starts;
    base_wr = wr_cnt;
    base_rd = rd_cnt;
    err_target = (c.err_start == 0) ? 0 : base_st + c.err_start;
    @(negedge wb_clk);
    go = 1'b1; src_addr = c.src; dst_addr = c.dst; word_count = c.count;
    @(negedge wb_clk);
    go = 1'b0; src_addr = 32'h0; dst_addr = 32'h0; word_count = 16'h0;
    check("busy_after_go", 32'(busy), 32'd1);
    check("err_cleared_by_go", 32'(err), 32'd0);
    seen = 1'b0;
    cyc = 0;
    while (!seen && cyc < 3000) begin
      if (inject && cyc == 2) begin
        go = 1'b1; src_addr = 32'hDEAD_0000; dst_addr = 32'hBEEF_0000; word_count = 16'd5;
      end
      if (inject && cyc == 3) go = 1'b0;
      if (done) seen = 1'b1;
      else begin
        @(negedge wb_clk);
        cyc++;
      end
    end
    go = 1'b0;
    if (!seen) begin
      check("done_timeout", 32'd0, 32'd1);
    end else begin
      if (c.count == 16'd0) check("zero_count_latency", 32'(cyc <= 1), 32'd1);
      check("words_done", 32'(words_done), 32'(c.exp_words));
      check("err_at_done", 32'(err), 32'(c.exp_err));
      check("master_idle_at_done", 32'(m_active), 32'd0);
      check("start_pulses", 32'(total_starts - base_st), 32'(c.exp_starts));
      @(negedge wb_clk);
      check("done_one_cycle", 32'(done), 32'd0);
      check("busy_cleared", 32'(busy), 32'd0);
      repeat (3) @(negedge wb_clk);
      check("no_extra_done", 32'(done), 32'd0);
      check("err_sticky", 32'(err), 32'(c.exp_err));
      check("write_count", 32'(wr_cnt - base_wr), 32'(c.exp_words));
      for (int i = 0; i < c.exp_words; i++) begin
        check("write_addr", wr_log_a[(base_wr + i) % 64], c.dst + 32'(4 * i));
        check("write_data", wr_log_d[(base_wr + i) % 64], rd_val(c.src + 32'(4 * i)));
      end
      n_rd = (c.exp_starts + 1) / 2;
      check("read_count", 32'(rd_cnt - base_rd), 32'(n_rd));
      for (int i = 0; i < n_rd; i++)
        check("read_addr", rd_log[(base_rd + i) % 64], c.src + 32'(4 * i));
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    cmd_t c;
    int   n;
    bit   seen;
    wb_rst_n = 1'b0; go = 1'b0;
    src_addr = 32'h0; dst_addr = 32'h0; word_count = 16'h0;
    repeat (3) @(negedge wb_clk);
    check("reset_start", 32'(mst_start), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_err", 32'(err), 32'd0);
    check("reset_words", 32'(words_done), 32'd0);
    check("reset_addr", mst_address, 32'h0);
    wb_rst_n = 1'b1;
    @(negedge wb_clk);
    check("idle_busy", 32'(busy), 32'd0);

    // Hand vectors with literal expectations
    tbl.push_back(mk(32'h0000_0100, 32'h0000_0200, 16'd3, 0, 0, 3, 1'b0, 6));
    tbl.push_back(mk(32'h0000_0100, 32'h0000_0200, 16'd0, 0, 0, 0, 1'b0, 0));
    tbl.push_back(mk(32'h0000_0100, 32'h0000_0200, 16'd3, 3, 0, 1, 1'b1, 3));
    tbl.push_back(mk(32'hFFFF_FFFC, 32'h0000_0300, 16'd2, 0, 1, 2, 1'b0, 4));
    tbl.push_back(mk(32'h0000_0400, 32'hFFFF_FFF8, 16'd3, 0, 0, 3, 1'b0, 6));
    tbl.push_back(mk(32'h0000_0100, 32'h0000_0200, 16'd2, 4, 1, 1, 1'b1, 4));
    tbl.push_back(mk(32'h0000_0010, 32'h0000_FFF0, 16'd1, 1, 2, 0, 1'b1, 1));
    // Randomized commands, expectations from the reference rules
    for (int k = 0; k < 20; k++) begin
      c.src   = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | (32'($urandom_range(0, 3)) << 2))
                                            : ($urandom & 32'hFFFF_FFFC);
      c.dst   = $urandom & 32'hFFFF_FFFC;
      c.count = 16'($urandom_range(0, 6));
      c.waits = $urandom_range(0, 3);
      c.err_start = (c.count != 16'd0 && $urandom_range(0, 2) == 0)
                    ? $urandom_range(1, 2 * int'(c.count)) : 0;
      tbl.push_back(expect_of(c));
    end
    foreach (tbl[i]) run_cmd(tbl[i], 1'b0);

    // go during busy with different operands must be ignored
    run_cmd(mk(32'h0000_0100, 32'h0000_0200, 16'd2, 0, 1, 2, 1'b0, 4), 1'b1);

    // Reset during WR_WAIT of the first word
    wait_states = 3;
    err_target  = 0;
    @(negedge wb_clk);
    go = 1'b1; src_addr = 32'h0000_0100; dst_addr = 32'h0000_0200; word_count = 16'd2;
    @(negedge wb_clk);
    go = 1'b0;
    seen = 1'b0;
    n = 0;
    while (!seen && n < 200) begin
      if (mst_start && mst_write) seen = 1'b1;
      else begin
        @(negedge wb_clk);
        n++;
      end
    end
    check("reset_test_write_seen", 32'(seen), 32'd1);
    @(negedge wb_clk);
    wb_rst_n = 1'b0;
    #1;
    check("midrst_start", 32'(mst_start), 32'd0);
    check("midrst_addr", mst_address, 32'h0);
    check("midrst_sel", 32'(mst_selection), 32'd0);
    check("midrst_write", 32'(mst_write), 32'd0);
    check("midrst_data", mst_data_wr, 32'h0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_words", 32'(words_done), 32'd0);
    check("midrst_err", 32'(err), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge wb_clk);
      check("midrst_no_done", 32'(done), 32'd0);
    end
    wb_rst_n = 1'b1;
    run_cmd(mk(32'h0000_0500, 32'h0000_0600, 16'd2, 0, 0, 2, 1'b0, 4), 1'b0);

    check("protocol_violations", 32'(proto_bad), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
